mem_arbiter: RTL and testbench
==============================

# mem_arbiter

- Shares one single-port unified memory between the CPU's instruction-fetch port and data-access port.
- Accepts a held request from each side, grants one at a time, and drives the memory strobes for a fixed number of cycles.
- Returns read data with a one-cycle `*_ready` pulse, which the pipeline uses as its memory-stall release.
- Sits between the `cpu` memory interfaces and the memory model. Tristate handling of the data buses is done outside this block.

## Interface

Parameters:
- `WORD_SIZE`, 16: address and data width.
- `MEM_LATENCY`, 2: cycles the memory strobes must be held per access; legal range 1..15.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `i_req`, in, 1: instruction-side request; held until `i_ready`.
- `i_we`, in, 1: instruction-side write (1) or read (0).
- `i_addr`, in, WORD_SIZE: instruction-side address.
- `i_wdata`, in, WORD_SIZE: instruction-side write data.
- `i_rdata`, out, WORD_SIZE: instruction-side read data; valid while `i_ready` is high.
- `i_ready`, out, 1: one-cycle completion pulse, instruction side.
- `d_req`, `d_we`, `d_addr`, `d_wdata`, `d_rdata`, `d_ready`: data side; same meanings as the instruction-side ports.
- `mem_read`, out, 1: memory read strobe.
- `mem_write`, out, 1: memory write strobe.
- `mem_addr`, out, WORD_SIZE: memory address.
- `mem_wdata`, out, WORD_SIZE: memory write data.
- `mem_rdata`, in, WORD_SIZE: memory read data; valid in the last strobe cycle.
- `grant_d`, out, 1: current or most recent grant went to the data side.
- `busy`, out, 1: high in ACCESS and DONE.

## Operation

State machine: IDLE, ACCESS, DONE.

- **IDLE**
  - If neither `i_req` nor `d_req` is high, stay in IDLE.
  - Otherwise arbitrate (see Configuration), latch the winner's `we`, `addr` and `wdata` into internal registers, set `grant_d`, load the wait counter with `MEM_LATENCY-1`, and go to ACCESS.
- **ACCESS**
  - `mem_addr` and `mem_wdata` are driven from the latched registers.
  - `mem_read` equals the latched `!we`; `mem_write` equals the latched `we`.
  - Counter decrements each cycle. When it is 0, capture `mem_rdata` into the granted side's rdata register (reads only) and go to DONE.
- **DONE**
  - Strobes are low.
  - The granted side's `ready` is high for exactly this cycle.
  - No arbitration happens in DONE, so a requester still holding `req` in this cycle is not served twice.
  - Next state is IDLE.

Data registers:
- `i_rdata` and `d_rdata` hold their last captured value until the next read completes on that side.
- Writes do not change `i_rdata` or `d_rdata`.

Protocol violations:
- If `req` drops or `addr` changes during ACCESS, the access still completes on the latched values and `ready` still pulses.
- If both strobes would be asserted, that is an internal error; it is impossible by construction because only one latched `we` exists.

## Timing

Reset values (next edge while `reset` is high):
- State is IDLE.
- All outputs are 0, including `i_rdata`, `d_rdata`, `grant_d` and `busy`.
- The counter and the round-robin pointer are cleared.

Latency:
- Request sampled in IDLE at edge 0.
- Strobes high for cycles 1..`MEM_LATENCY`.
- `ready` high in cycle `MEM_LATENCY+1`.
- Back in IDLE at cycle `MEM_LATENCY+2`.
- Throughput: at most one access per `MEM_LATENCY+2` cycles.

Boundary cases:
- `MEM_LATENCY=1`: the ACCESS state lasts one cycle.
- Reset during ACCESS or DONE: the access is aborted, strobes drop at that edge, no `ready` pulse is issued, and `rdata` returns to 0.
- A request arriving in DONE is sampled in the following IDLE cycle.
- The losing side's request is held pending and served on the next IDLE cycle, with no extra delay.

## Configuration

Macro: `MEM_ARB_ROUND_ROBIN_EN`.
- **Defined:**
  - On simultaneous requests, grant the side not granted last time.
  - The last-grant pointer updates on every grant and resets to "instruction".
  - The first conflict after reset therefore grants data.
- **Undefined:**
  - Fixed priority: data always wins a conflict.
  - No pointer register exists.
- With a single requester, both builds behave identically.

## Test plan

1. **Instruction read alone.** Reset, `MEM_LATENCY=2`, `i_req=1`, `i_we=0`, `i_addr=0x0010`, memory returns 0xBEEF.
   - Required: `mem_read` high exactly 2 cycles with `mem_addr=0x0010`.
   - Required: `i_ready` pulses once with `i_rdata=0xBEEF` in cycle 3.
   - Required: `d_ready` stays 0.
2. **Data write alone.** `d_req=1`, `d_we=1`, `d_addr=0x0200`, `d_wdata=0x1234`.
   - Required: `mem_write` high 2 cycles with `mem_wdata=0x1234`.
   - Required: `d_ready` pulses once and `d_rdata` is unchanged.
3. **Conflict, fixed priority (macro undefined).** `i_req` and `d_req` rise together.
   - Required: data is served first (`grant_d=1`), then instruction.
   - Required: `i_ready` lands exactly `MEM_LATENCY+2` cycles after `d_ready`.
4. **Conflict, round-robin (macro defined).** Two back-to-back conflicts.
   - Required grant order: D, I, D, I.
5. **Reset mid-access.** Assert `reset` during the second ACCESS cycle.
   - Required: strobes are 0 at the next edge, no `ready` pulse, and all outputs are 0.
6. **Held request through DONE.** Requester keeps `i_req` high one cycle past `i_ready`.
   - Required: a second access starts only from IDLE; exactly one extra access is served, with no double `ready` in the DONE cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction-fetch and
// data-access ports, one fixed-length access at a time, with a one-cycle ready pulse.
// Build option: define MEM_ARB_ROUND_ROBIN_EN to alternate grants on conflicts;
// without it the data side always wins a conflict.
module mem_arbiter #(
    parameter int unsigned WORD_SIZE   = 16,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic                 i_we,
    input  logic [WORD_SIZE-1:0] i_addr,
    input  logic [WORD_SIZE-1:0] i_wdata,
    output logic [WORD_SIZE-1:0] i_rdata,
    output logic                 i_ready,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_ready,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 grant_d,
    output logic                 busy
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 we_q, we_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic                 grant_data_q, grant_data_d;
    logic                 mem_read_q, mem_read_d;
    logic                 mem_write_q, mem_write_d;
    logic                 i_ready_q, i_ready_d;
    logic                 d_ready_q, d_ready_d;
    logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
    logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
    logic                 busy_q, busy_d;
    logic                 pick_data;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_d_q, last_d_d;

    // Conflict goes to the side not granted last time; pointer updates on every grant.
    always_comb begin
        pick_data = d_req && (!i_req || !last_d_q);
        last_d_d  = last_d_q;
        if (state_q == IDLE && (i_req || d_req)) begin
            last_d_d = pick_data;
        end
    end

    // Last-grant pointer, cleared to "instruction" so the first conflict grants data.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`else
    // Fixed priority: data wins any conflict.
    always_comb begin
        pick_data = d_req;
    end
`endif

    // Next-state and registered-output computation for IDLE -> ACCESS -> DONE.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        grant_data_d = grant_data_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        i_ready_d    = 1'b0;
        d_ready_d    = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    state_d      = ACCESS;
                    grant_data_d = pick_data;
                    we_d         = pick_data ? d_we    : i_we;
                    addr_d       = pick_data ? d_addr  : i_addr;
                    wdata_d      = pick_data ? d_wdata : i_wdata;
                    cnt_d        = CNT_W'(MEM_LATENCY - 1);
                    mem_read_d   = !we_d;
                    mem_write_d  = we_d;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    // Last strobe cycle: memory data is valid now.
                    state_d   = DONE;
                    i_ready_d = !grant_data_q;
                    d_ready_d = grant_data_q;
                    if (!we_q) begin
                        if (grant_data_q) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            i_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_d       = cnt_q - CNT_W'(1);
                    mem_read_d  = !we_q;
                    mem_write_d = we_q;
                end
            end
            DONE: begin
                // No arbitration here, so a still-held request is not served twice.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset; reset aborts any access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            grant_data_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            i_ready_q    <= 1'b0;
            d_ready_q    <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            grant_data_q <= grant_data_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            i_ready_q    <= i_ready_d;
            d_ready_q    <= d_ready_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign grant_d   = grant_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed plus randomized traffic for mem_arbiter, checked every
// cycle against a transaction-level schedule model and a reference memory.
module tb_mem_arbiter;

    localparam int unsigned W     = 16;
    localparam int unsigned LAT   = 2;
    localparam int unsigned N_CYC = 3000;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_req, i_we, i_ready;
    logic [W-1:0] i_addr, i_wdata, i_rdata;
    logic         d_req, d_we, d_ready;
    logic [W-1:0] d_addr, d_wdata, d_rdata;
    logic         mem_read, mem_write;
    logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
    logic         grant_d, busy;

    mem_arbiter #(.WORD_SIZE(W), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .grant_d(grant_d), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = -1;

    // Requester state (index 0 = instruction, 1 = data).
    bit           rq [2];
    bit           rwe [2];
    logic [W-1:0] raddr [2];
    logic [W-1:0] rwdata [2];

    // Reference model: current transaction, arbiter availability, visible state.
    bit           act_valid = 1'b0;
    int           act_s = 0;
    int           act_w = 0;
    bit           act_we;
    logic [W-1:0] act_addr, act_wdata;
    int           free_at = 0;
    bit           exp_gd = 1'b0;
    bit           last_w = 1'b0;
    logic [W-1:0] exp_rdat [2];
    logic [W-1:0] ref_mem [16];
    logic [W-1:0] phy_mem [16];
    bit           model_known = 1'b0;
    bit           just_reset = 1'b0;
    bit           want_reset = 1'b0;
    bit           rand_mode = 1'b0;
    int unsigned  run = 0;

    int n_iready = 0, n_dready = 0, n_rd_cyc = 0, n_wr_cyc = 0;
    int ready_cyc [$];
    bit ready_side [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic post(input int s, input bit we, input logic [W-1:0] a, input logic [W-1:0] wd);
        rq[s]     = 1'b1;
        rwe[s]    = we;
        raddr[s]  = a;
        rwdata[s] = wd;
    endtask

    // Compare this cycle's outputs with what the transaction schedule implies.
    task automatic check_cycle();
        bit e_busy = 1'b0, e_rd = 1'b0, e_wr = 1'b0, e_ir = 1'b0, e_dr = 1'b0, in_acc = 1'b0;
        int k;
        if (act_valid) begin
            k = cyc - act_s;
            if (k >= 1 && k <= int'(LAT)) begin
                in_acc = 1'b1;
                e_busy = 1'b1;
                e_rd   = !act_we;
                e_wr   = act_we;
            end else if (k == int'(LAT) + 1) begin
                e_busy = 1'b1;
                if (act_w == 1) e_dr = 1'b1; else e_ir = 1'b1;
                if (act_we) ref_mem[act_addr[3:0]] = act_wdata;
                else        exp_rdat[act_w] = ref_mem[act_addr[3:0]];
                rq[act_w] = 1'b0;
                act_valid = 1'b0;
            end
        end
        chk("busy", 32'(busy), 32'(e_busy));
        chk("mem_read", 32'(mem_read), 32'(e_rd));
        chk("mem_write", 32'(mem_write), 32'(e_wr));
        chk("i_ready", 32'(i_ready), 32'(e_ir));
        chk("d_ready", 32'(d_ready), 32'(e_dr));
        chk("grant_d", 32'(grant_d), 32'(exp_gd));
        chk("i_rdata", 32'(i_rdata), 32'(exp_rdat[0]));
        chk("d_rdata", 32'(d_rdata), 32'(exp_rdat[1]));
        if (in_acc) begin
            chk("mem_addr", 32'(mem_addr), 32'(act_addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(act_wdata));
        end
        if (just_reset) begin
            chk("rst_mem_addr", 32'(mem_addr), 32'h0);
            chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
            just_reset = 1'b0;
        end
    endtask

    // Mid-cycle sample point: check, record events, present memory read data.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (model_known) check_cycle();
        if (i_ready) begin n_iready++; ready_cyc.push_back(cyc); ready_side.push_back(1'b0); end
        if (d_ready) begin n_dready++; ready_cyc.push_back(cyc); ready_side.push_back(1'b1); end
        if (mem_read)  n_rd_cyc++;
        if (mem_write) n_wr_cyc++;
        run = (mem_read || mem_write) ? run + 1 : 0;
        mem_rdata = (mem_read && run == LAT) ? phy_mem[mem_addr[3:0]] : ~phy_mem[mem_addr[3:0]];
    endtask

    task automatic drive_ports();
        bit scr0, scr1;
        scr0 = rand_mode && act_valid && act_s < cyc && act_w == 0;
        scr1 = rand_mode && act_valid && act_s < cyc && act_w == 1;
        i_req   = rq[0];
        i_we    = scr0 ? 1'($urandom_range(0, 1)) : rwe[0];
        i_addr  = scr0 ? W'($urandom) : raddr[0];
        i_wdata = scr0 ? W'($urandom) : rwdata[0];
        d_req   = rq[1];
        d_we    = scr1 ? 1'($urandom_range(0, 1)) : rwe[1];
        d_addr  = scr1 ? W'($urandom) : raddr[1];
        d_wdata = scr1 ? W'($urandom) : rwdata[1];
    endtask

    // Decide what the coming edge does: reset, memory write, and which side is granted.
    task automatic commit();
        bit rst_now;
        int w;
        if (rand_mode) begin
            for (int s = 0; s < 2; s++) begin
                if (!rq[s] && $urandom_range(0, 99) < 35)
                    post(s, 1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
            end
            if (act_valid && $urandom_range(0, 99) < 2) want_reset = 1'b1;
        end
        rst_now    = want_reset;
        want_reset = 1'b0;
        if (mem_write && run == LAT && !rst_now) phy_mem[mem_addr[3:0]] = mem_wdata;
        if (rst_now) begin
            act_valid   = 1'b0;
            exp_rdat[0] = '0;
            exp_rdat[1] = '0;
            exp_gd      = 1'b0;
            last_w      = 1'b0;
            rq[0]       = 1'b0;
            rq[1]       = 1'b0;
            free_at     = cyc + 1;
            model_known = 1'b1;
            just_reset  = 1'b1;
        end else if (cyc >= free_at && (rq[0] || rq[1])) begin
            if (rq[0] && rq[1]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                w = last_w ? 0 : 1;
`else
                w = 1;
`endif
            end else begin
                w = rq[1] ? 1 : 0;
            end
            act_valid = 1'b1;
            act_s     = cyc;
            act_w     = w;
            act_we    = rwe[w];
            act_addr  = raddr[w];
            act_wdata = rwdata[w];
            exp_gd    = (w == 1);
            last_w    = (w == 1);
            free_at   = cyc + int'(LAT) + 2;
        end
        reset = rst_now;
        drive_ports();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            commit();
        end
    endtask

    // Advance until all posted requests are served; leaves the last cycle uncommitted.
    task automatic wait_served(input int budget);
        int k = 0;
        forever begin
            tick();
            k++;
            if (!(rq[0] || rq[1]) || k >= budget) break;
            commit();
        end
        chk("serve_timeout", 32'(rq[0] || rq[1]), 32'h0);
    endtask

    initial begin
        int b_ir, b_dr, b_rd, b_wr, k;
        bit exp_order [4];
        exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
        reset = 1'b1;
        mem_rdata = '0;
        rq[0] = 1'b0; rq[1] = 1'b0;
        for (int s = 0; s < 2; s++) begin
            rwe[s] = 1'b0; raddr[s] = '0; rwdata[s] = '0; exp_rdat[s] = '0;
        end
        drive_ports();
        for (int m = 0; m < 16; m++) begin
            phy_mem[m] = W'($urandom);
            ref_mem[m] = phy_mem[m];
        end
        phy_mem[0] = 16'hBEEF;
        ref_mem[0] = 16'hBEEF;

        want_reset = 1'b1; tick(); commit();
        want_reset = 1'b1; tick(); commit();

        // Instruction read alone.
        b_ir = n_iready; b_dr = n_dready; b_rd = n_rd_cyc;
        tick(); post(0, 1'b0, 16'h0010, 16'h5555); commit();
        idle(int'(LAT) + 3);
        chk("t1_iready_cnt", 32'(n_iready - b_ir), 32'd1);
        chk("t1_dready_cnt", 32'(n_dready - b_dr), 32'd0);
        chk("t1_read_cycles", 32'(n_rd_cyc - b_rd), 32'(LAT));
        chk("t1_rdata", 32'(i_rdata), 32'h0000BEEF);

        // Data write alone.
        b_dr = n_dready; b_wr = n_wr_cyc;
        tick(); post(1, 1'b1, 16'h0200, 16'h1234); commit();
        idle(int'(LAT) + 3);
        chk("t2_dready_cnt", 32'(n_dready - b_dr), 32'd1);
        chk("t2_write_cycles", 32'(n_wr_cyc - b_wr), 32'(LAT));
        chk("t2_rdata_kept", 32'(d_rdata), 32'h0);

        // Two back-to-back conflicts from reset: order D, I, D, I in both builds.
        tick(); want_reset = 1'b1; commit();
        ready_cyc.delete(); ready_side.delete();
        tick(); post(0, 1'b0, 16'h0031, '0); post(1, 1'b0, 16'h0042, '0); commit();
        wait_served(40);
        post(0, 1'b0, 16'h0033, '0); post(1, 1'b1, 16'h0044, 16'hA5A5); commit();
        wait_served(40);
        commit();
        idle(4);
        chk("t3_ready_count", 32'(ready_side.size()), 32'd4);
        if (ready_side.size() >= 4) begin
            for (int j = 0; j < 4; j++) chk("t3_order", 32'(ready_side[j]), 32'(exp_order[j]));
            for (int j = 1; j < 4; j++) chk("t3_gap", 32'(ready_cyc[j] - ready_cyc[j-1]), 32'(LAT + 2));
        end

        // Reset during the second ACCESS cycle.
        b_ir = n_iready;
        tick(); post(0, 1'b0, 16'h0077, '0); commit();
        tick(); commit();
        tick(); want_reset = 1'b1; commit();
        idle(int'(LAT) + 3);
        chk("t5_no_ready", 32'(n_iready - b_ir), 32'd0);
        chk("t5_rdata", 32'(i_rdata), 32'h0);

        // Request held through DONE: exactly one extra access.
        tick(); post(0, 1'b0, 16'h0005, '0); commit();
        b_ir = n_iready;
        k = 0;
        do begin
            tick();
            k++;
            if (n_iready == b_ir && k < 20) commit();
        end while (n_iready == b_ir && k < 20);
        post(0, 1'b0, 16'h0005, '0); commit();
        tick(); commit();
        tick(); rq[0] = 1'b0; commit();
        idle(int'(LAT) + 4);
        chk("t6_iready_cnt", 32'(n_iready - b_ir), 32'd2);

        // Randomized traffic with occasional resets and address changes mid-access.
        rand_mode = 1'b1;
        idle(int'(N_CYC));
        rand_mode = 1'b0;
        idle(2 * int'(LAT) + 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
